// File: rtl/axis_adc_frame_capture_if.sv
// AXI4-Stream channel used by the ADC frame capture block.
// The master drives tvalid/tdata/tlast; the slave drives tready.
interface axis_adc_frame_capture_if #(
    parameter int TDATA_WIDTH = 32
) ();
    logic                   tvalid;
    logic                   tready;
    logic [TDATA_WIDTH-1:0] tdata;
    logic                   tlast;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_adc_frame_capture.sv
// ADC front end: offset-binary to negated two's complement, complex packing, triggered frame capture into a FIFO.
// Optional macro AXIS_ADC_DECIMATION_EN adds cfg_decimation (push every Nth capture cycle).
//
// state   | meaning
// IDLE    | waiting for trig with a non-zero sample count
// CAPTURE | pushing one converted sample per slot until the count runs out
// DRAIN   | capture done, waiting for the FIFO and output register to empty
module axis_adc_frame_capture #(
    parameter int ADC_DATA_WIDTH   = 14,
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int FIFO_DEPTH       = 16,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    output logic                      adc_csn,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_a,
    input  logic [ADC_DATA_WIDTH-1:0] adc_dat_b,
    input  logic [1:0]                adc_channel_switch,
    input  logic [CNTR_WIDTH-1:0]     cfg_sample_count,
`ifdef AXIS_ADC_DECIMATION_EN
    input  logic [15:0]               cfg_decimation,
`endif
    input  logic                      trig,
    output logic                      busy,
    output logic                      overflow,
    axis_adc_frame_capture_if.master  m_axis
);
    localparam int H  = AXIS_TDATA_WIDTH / 2;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = AXIS_TDATA_WIDTH + 1;

    if (ADC_DATA_WIDTH >= H) begin : g_bad_adc_width
        $error("ADC_DATA_WIDTH must be less than AXIS_TDATA_WIDTH/2");
    end
    if ((H % 8) != 0) begin : g_bad_tdata_width
        $error("AXIS_TDATA_WIDTH/2 must be a multiple of 8");
    end
    if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2 and at least 4");
    end

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

    function automatic logic [H-1:0] conv(input logic [ADC_DATA_WIDTH-1:0] x);
        logic [H-1:0] ext;
        ext = {{(H-ADC_DATA_WIDTH+1){~x[ADC_DATA_WIDTH-1]}}, x[ADC_DATA_WIDTH-2:0]};
        return -ext;
    endfunction

    state_t                    state;
    logic [ADC_DATA_WIDTH-1:0] dat_a_q;
    logic [ADC_DATA_WIDTH-1:0] dat_b_q;
    logic [1:0]                switch_q;
    logic [CNTR_WIDTH-1:0]     remaining;
    logic [EW-1:0]             mem [FIFO_DEPTH];
    logic [AW-1:0]             wr_ptr;
    logic [AW-1:0]             rd_ptr;
    logic [AW:0]               fifo_count;
    logic [AW:0]               occupancy;
    logic                      tvalid_q;
    logic                      tlast_q;
    logic [AXIS_TDATA_WIDTH-1:0] tdata_q;
    logic                      overflow_q;
    logic [H-1:0]              conv_a;
    logic [H-1:0]              conv_b;
    logic [AXIS_TDATA_WIDTH-1:0] sample_data;
    logic                      accept;
    logic                      load;
    logic                      full_after_pop;
    logic                      dec_hit;
    logic                      sample_slot;
    logic                      push;
    logic                      last_slot;

`ifdef AXIS_ADC_DECIMATION_EN
    logic [15:0] dec_q;
    logic [15:0] dec_cnt;
    assign dec_hit = (dec_cnt == 16'd0);
`else
    assign dec_hit = 1'b1;
`endif

    assign adc_csn = 1'b1;

    // Input stage has no reset: it just retimes the ADC pins.
    always_ff @(posedge aclk) begin
        dat_a_q  <= adc_dat_a;
        dat_b_q  <= adc_dat_b;
        switch_q <= adc_channel_switch;
    end

    assign conv_a = conv(dat_a_q);
    assign conv_b = conv(dat_b_q);

    always_comb begin
        sample_data = '0;
        unique case (switch_q)
            2'b00: sample_data = {conv_a, conv_b};
            2'b01: sample_data = {{H{1'b0}}, conv_a};
            2'b10: sample_data = {{H{1'b0}}, conv_b};
            2'b11: sample_data = {{H{1'b0}}, conv_a - conv_b};
        endcase
    end

    // The output register counts as one FIFO entry so total buffering is FIFO_DEPTH.
    assign accept         = tvalid_q && m_axis.tready;
    assign occupancy      = fifo_count + (AW+1)'(tvalid_q);
    assign full_after_pop = (occupancy == (AW+1)'(FIFO_DEPTH)) && !accept;
    assign load           = (!tvalid_q || m_axis.tready) && (fifo_count != '0);
    assign sample_slot    = (state == S_CAPTURE) && dec_hit;
    assign push           = sample_slot && !full_after_pop;
    assign last_slot      = (remaining == CNTR_WIDTH'(1));

    always_ff @(posedge aclk) begin
        if (push) begin
            mem[wr_ptr] <= {last_slot, sample_data};
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state      <= S_IDLE;
            remaining  <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            tdata_q    <= '0;
            overflow_q <= 1'b0;
`ifdef AXIS_ADC_DECIMATION_EN
            dec_q      <= '0;
            dec_cnt    <= '0;
`endif
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (load) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(load);

            if (!tvalid_q || m_axis.tready) begin
                tvalid_q <= load;
                if (load) begin
                    {tlast_q, tdata_q} <= mem[rd_ptr];
                end else begin
                    tlast_q <= 1'b0;
                end
            end

            unique case (state)
                S_IDLE: begin
                    if (trig && cfg_sample_count != '0) begin
                        state      <= S_CAPTURE;
                        remaining  <= cfg_sample_count;
                        overflow_q <= 1'b0;
`ifdef AXIS_ADC_DECIMATION_EN
                        dec_q      <= cfg_decimation;
                        dec_cnt    <= '0;
`endif
                    end
                end
                S_CAPTURE: begin
`ifdef AXIS_ADC_DECIMATION_EN
                    dec_cnt <= dec_hit ? dec_q : dec_cnt - 16'd1;
`endif
                    if (sample_slot) begin
                        if (full_after_pop) begin
                            overflow_q <= 1'b1;
                        end
                        remaining <= remaining - 1'b1;
                        if (last_slot) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (occupancy == '0 || (occupancy == (AW+1)'(1) && accept)) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy          = (state != S_IDLE);
    assign overflow      = overflow_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tlast  = tlast_q;
endmodule

// File: tb/tb_axis_adc_frame_capture.sv
// Directed bench for axis_adc_frame_capture: latency, packing modes, stalls, overflow, reset, ignored triggers.
module tb_axis_adc_frame_capture;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        adc_csn;
    logic [13:0] adc_a = '0;
    logic [13:0] adc_b = '0;
    logic [1:0]  adc_sw = 2'b01;
    logic [31:0] cfg_count = '0;
`ifdef AXIS_ADC_DECIMATION_EN
    logic [15:0] cfg_dec = '0;
`endif
    logic        trig = 1'b0;
    logic        busy;
    logic        overflow;

    int n_checks = 0;
    int n_fail = 0;

    logic [32:0] beats[$];
    logic [32:0] exp_beats[$];

    axis_adc_frame_capture_if #(.TDATA_WIDTH(32)) m_if ();

    axis_adc_frame_capture dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .adc_csn            (adc_csn),
        .adc_dat_a          (adc_a),
        .adc_dat_b          (adc_b),
        .adc_channel_switch (adc_sw),
        .cfg_sample_count   (cfg_count),
`ifdef AXIS_ADC_DECIMATION_EN
        .cfg_decimation     (cfg_dec),
`endif
        .trig               (trig),
        .busy               (busy),
        .overflow           (overflow),
        .m_axis             (m_if)
    );

    always #5 aclk = ~aclk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offset-binary value minus midscale, then negated.
    function automatic logic [15:0] cv(input logic [13:0] x);
        int v;
        v = 8192 - int'(x);
        return 16'(v);
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic exp_push(input logic last, input logic [31:0] d);
        exp_beats.push_back({last, d});
    endtask

    task automatic check_frame(input string tag);
        check_val({tag, "_len"}, 64'(beats.size()), 64'(exp_beats.size()));
        for (int i = 0; i < exp_beats.size() && i < beats.size(); i++) begin
            check_val($sformatf("%s_beat%0d", tag, i), 64'(beats[i]), 64'(exp_beats[i]));
        end
        beats.delete();
        exp_beats.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while ((busy || m_if.tvalid) && n < budget) begin
            cyc(1);
            n++;
        end
        check_val({tag, "_idle"}, 64'(busy || m_if.tvalid), 64'(0));
    endtask

    // Trigger at the next edge and ramp channel A by one per cycle for n edges.
    task automatic run_ramp(input logic [13:0] base, input int n);
        adc_a = base;
        trig  = 1'b1;
        for (int i = 1; i <= n; i++) begin
            cyc(1);
            trig  = 1'b0;
            adc_a = base + 14'(i);
        end
    endtask

    // Beat capture and stall-stability monitor on the falling edge.
    logic        stall_prev = 1'b0;
    logic [32:0] stall_word = '0;
    always @(negedge aclk) begin
        if (aresetn && stall_prev) begin
            check_val("stall_tvalid", 64'(m_if.tvalid), 64'(1));
            check_val("stall_word", 64'({m_if.tlast, m_if.tdata}), 64'(stall_word));
        end
        if (aresetn && m_if.tvalid && m_if.tready) begin
            beats.push_back({m_if.tlast, m_if.tdata});
        end
        stall_prev = aresetn && m_if.tvalid && !m_if.tready;
        stall_word = {m_if.tlast, m_if.tdata};
    end

    initial begin
        m_if.tready = 1'b1;
        cyc(3);
        check_val("rst_tvalid", 64'(m_if.tvalid), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_overflow", 64'(overflow), 64'(0));
        check_val("rst_tlast", 64'(m_if.tlast), 64'(0));
        check_val("rst_tdata", 64'(m_if.tdata), 64'(0));
        check_val("adc_csn", 64'(adc_csn), 64'(1));
        aresetn = 1'b1;
        cyc(2);

        // Single-sample frame, mode 01, latency check
        adc_sw = 2'b01; adc_a = 14'h3FFF; cfg_count = 1;
        trig = 1'b1;
        cyc(1);
        trig = 1'b0;
        check_val("t1_busy", 64'(busy), 64'(1));
        check_val("t1_tvalid_k", 64'(m_if.tvalid), 64'(0));
        cyc(1);
        check_val("t1_tvalid_k1", 64'(m_if.tvalid), 64'(0));
        cyc(1);
        check_val("t1_tvalid_k2", 64'(m_if.tvalid), 64'(1));
        check_val("t1_tdata", 64'(m_if.tdata), 64'h0000_E001);
        check_val("t1_tlast", 64'(m_if.tlast), 64'(1));
        cyc(1);
        check_val("t1_busy_end", 64'(busy), 64'(0));
        check_val("t1_tvalid_end", 64'(m_if.tvalid), 64'(0));
        exp_push(1'b0 | 1'b1, {16'h0, cv(14'h3FFF)});
        check_frame("t1");

        // Mode 00 then mode 11, four samples each
        adc_sw = 2'b00; adc_a = 14'h0000; adc_b = 14'h3FFF; cfg_count = 4;
        trig = 1'b1; cyc(1); trig = 1'b0;
        wait_idle("t2a", 50);
        for (int i = 0; i < 4; i++) exp_push(i == 3, 32'h2000_E001);
        check_frame("t2a");
        adc_sw = 2'b11;
        cyc(1);
        trig = 1'b1; cyc(1); trig = 1'b0;
        wait_idle("t2b", 50);
        for (int i = 0; i < 4; i++) exp_push(i == 3, {16'h0, 16'(cv(14'h0000) - cv(14'h3FFF))});
        check_frame("t2b");

        // Eight-sample ramp with the sink stalled
        adc_sw = 2'b01; cfg_count = 8; m_if.tready = 1'b0;
        cyc(1);
        run_ramp(14'h0100, 7);
        cyc(2);
        check_val("t3_stall_tvalid", 64'(m_if.tvalid), 64'(1));
        check_val("t3_stall_beats", 64'(beats.size()), 64'(0));
        m_if.tready = 1'b1;
        wait_idle("t3", 50);
        check_val("t3_overflow", 64'(overflow), 64'(0));
        for (int i = 0; i < 8; i++) exp_push(i == 7, {16'h0, cv(14'h0100 + 14'(i))});
        check_frame("t3");

        // Overflow: 40 samples into 16 entries with the sink stalled
        cfg_count = 40; m_if.tready = 1'b0;
        run_ramp(14'h0200, 45);
        check_val("t4_overflow", 64'(overflow), 64'(1));
        check_val("t4_busy", 64'(busy), 64'(1));
        m_if.tready = 1'b1;
        wait_idle("t4", 100);
        check_val("t4_overflow_sticky", 64'(overflow), 64'(1));
        for (int i = 0; i < 16; i++) exp_push(1'b0, {16'h0, cv(14'h0200 + 14'(i))});
        check_frame("t4");
        cfg_count = 1;
        trig = 1'b1; cyc(1); trig = 1'b0;
        check_val("t4_overflow_clear", 64'(overflow), 64'(0));
        wait_idle("t4c", 20);
        beats.delete();

        // Reset in the middle of a 10-sample frame
        cfg_count = 10;
        run_ramp(14'h0400, 3);
        beats.delete();
        aresetn = 1'b0;
        cyc(1);
        aresetn = 1'b1;
        check_val("t5_tvalid", 64'(m_if.tvalid), 64'(0));
        check_val("t5_busy", 64'(busy), 64'(0));
        check_val("t5_tdata", 64'(m_if.tdata), 64'(0));
        check_val("t5_overflow", 64'(overflow), 64'(0));
        cyc(4);
        check_val("t5_flushed", 64'(beats.size()), 64'(0));
        check_val("t5_tvalid_later", 64'(m_if.tvalid), 64'(0));

        // Clean frame after reset; extra trig while busy is ignored
        run_ramp(14'h0500, 4);
        trig = 1'b1; cyc(1); trig = 1'b0;
        wait_idle("t5b", 50);
        for (int i = 0; i < 10; i++) exp_push(i == 9, {16'h0, cv(14'h0500 + 14'(i < 4 ? i : 4))});
        check_frame("t5b");

        // Trig with a zero count is ignored
        cfg_count = 0;
        trig = 1'b1; cyc(1); trig = 1'b0;
        check_val("t5_zero_busy", 64'(busy), 64'(0));
        cyc(5);
        check_val("t5_zero_beats", 64'(beats.size()), 64'(0));

`ifdef AXIS_ADC_DECIMATION_EN
        // Decimation by 4: samples 0, 4, 8, 12 of the ramp
        cfg_count = 4; cfg_dec = 16'd3;
        run_ramp(14'h0300, 14);
        wait_idle("t6", 50);
        for (int i = 0; i < 4; i++) exp_push(i == 3, {16'h0, cv(14'h0300 + 14'(4 * i))});
        check_frame("t6");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/axis_adc_frame_capture.md
Name: axis_adc_frame_capture

Overview:
Next-generation Red Pitaya ADC front end. It converts offset-binary ADC samples to sign-extended, negated two's complement and packs them as complex AXIS words with a selectable channel mode. It captures triggered frames of programmable length into an internal FIFO. Unlike the free-running predecessor, it honours m_axis_tready, marks frame ends with tlast, and reports overflow. It sits between the ADC pins and the downstream DDC/DMA chain.

Parameters:
ADC_DATA_WIDTH, 14, ADC sample width; must be < AXIS_TDATA_WIDTH/2 (elaboration error otherwise).
AXIS_TDATA_WIDTH, 32, output width; AXIS_TDATA_WIDTH/2 must be a multiple of 8 (elaboration error otherwise).
FIFO_DEPTH, 16, capture FIFO entries; power of 2, >= 4.
CNTR_WIDTH, 32, width of the frame-length counter.

Ports:
aclk  in  1  single clock.
aresetn  in  1  synchronous, active-low reset.
adc_csn  out  1  ADC chip select, constant 1.
adc_dat_a  in  ADC_DATA_WIDTH  channel A raw offset-binary.
adc_dat_b  in  ADC_DATA_WIDTH  channel B raw offset-binary.
adc_channel_switch  in  2  packing mode.
cfg_sample_count  in  CNTR_WIDTH  samples per frame.
trig  in  1  frame start; level sampled each cycle.
busy  out  1  frame in progress or draining.
overflow  out  1  sticky; a sample was dropped in the current or last frame.
m_axis_tvalid  out  1  AXIS valid.
m_axis_tready  in  1  AXIS ready.
m_axis_tdata  out  AXIS_TDATA_WIDTH  {imag, real}; H = AXIS_TDATA_WIDTH/2.
m_axis_tlast  out  1  last sample of a frame.

Behaviour:
- Input stage: adc_dat_a, adc_dat_b and adc_channel_switch are registered every cycle, regardless of reset or state.
- Conversion: conv(x) = -(sign-extend to H bits of {~x[MSB], x[MSB-1:0]}).
- Packing modes:
  - 00: tdata = {conv(a), conv(b)}.
  - 01: tdata = {H'0, conv(a)}.
  - 10: tdata = {H'0, conv(b)}.
  - 11 (new, differential): tdata = {H'0, conv(a) - conv(b)} in H bits. No overflow is possible because H >= ADC_DATA_WIDTH+1.
- FSM IDLE / CAPTURE / DRAIN; busy = (state != IDLE).
  - IDLE: trig high at edge k and cfg_sample_count != 0 -> latch the count and enter CAPTURE at k+1; overflow is cleared at the same edge. trig with count 0 is ignored.
  - CAPTURE: one converted sample is pushed per cycle; the remaining count decrements each cycle whether or not the push succeeds. The final sample carries tlast=1. After the final push -> DRAIN.
  - DRAIN: exit to IDLE on the cycle the FIFO becomes empty (the last beat is accepted).
  - trig is ignored while busy.
- Latency: trig sampled at edge k -> first push at edge k+1 -> m_axis_tvalid high after edge k+2.
- FIFO full on push:
  - A sample is dropped and overflow is set. A dropped final sample loses its tlast; overflow flags the corrupt frame.
  - Fullness is evaluated after the same-cycle pop, so push + pop while full succeeds.
- AXIS rules:
  - tvalid is held until tready.
  - tdata and tlast stay stable while tvalid && !tready.
  - tvalid is never dependent on tready combinationally.
- Reset (including mid-frame): state IDLE, FIFO flushed, busy=0, overflow=0, tvalid=0, tlast=0, tdata=0. No partial frame is completed.

Optional Feature:
AXIS_ADC_DECIMATION_EN:
- Defined: adds input cfg_decimation [15:0]. During CAPTURE a sample is pushed only every (cfg_decimation+1)th cycle, starting with the first CAPTURE cycle. The count decrements per pushed sample only. The value is latched at trig.
- Undefined: the port is absent and a sample is pushed every CAPTURE cycle.

Test Plan:
1. Mode 01, a=0x3FFF, count=1, tready=1, trig pulse -> one beat tdata=0x0000E001, tlast=1; tvalid high 2 cycles after trig; busy back to 0.
2. Mode 00, a=0x0000, b=0x3FFF, count=4 -> 4 beats of 0x2000E001, tlast only on beat 4; mode 11 with same inputs -> 0x00003FFF.
3. count=8, tready held low for 8 cycles then released -> 8 beats in order, no drops, overflow=0, tvalid/tdata stable while stalled.
4. FIFO_DEPTH=16, count=40, tready=0 throughout CAPTURE -> exactly 16 beats delivered after release, overflow=1, no tlast; next trig clears overflow.
5. aresetn low for 1 cycle at sample 3 of a 10-sample frame -> next cycle tvalid=0, busy=0, FIFO empty; a subsequent trig produces a clean 10-beat frame. A trig while busy, and a trig with count=0, are both ignored.
6. With AXIS_ADC_DECIMATION_EN, decimation=3, count=4, ramp input -> beats equal samples 0, 4, 8, 12 of the ramp; tlast on the 4th beat.
